ccff_loader: RTL

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 6 +
 rtl/ccff_tail_checker.sv | 32 +++
 rtl/ccff_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared FSM states and widths for the configuration-chain loader.
package ccff_pkg;
    typedef enum logic [2:0] {IDLE, PRESET, LOAD, SHIFT, CHECK, DONE} state_t;
    localparam int WORD_W = 32;
    localparam int CHECK_LEN = 8;
endpackage

// File: rtl/ccff_tail_checker.sv
// ccff_tail_checker: latches the first payload bits and compares them against the chain tail.
// Compiled only when CCFF_TAIL_CHECK_EN is defined.
`ifdef CCFF_TAIL_CHECK_EN
module ccff_tail_checker
    import ccff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_cap,
    input  logic i_bit,
    input  logic i_chk,
    input  logic i_tail,
    output logic o_err
);
    logic [CHECK_LEN-1:0] r_pl;
    logic                 r_err;
    // r_pl[CHECK_LEN-1] always holds the next payload bit expected on the tail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pl  <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_cap) r_pl <= {r_pl[CHECK_LEN-2:0], i_bit};
            else if (i_chk) r_pl <= {r_pl[CHECK_LEN-2:0], 1'b0};
            if (i_clr) r_err <= 1'b0;
            else if (i_chk && (i_tail != r_pl[CHECK_LEN-1])) r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
endmodule
`endif

// File: rtl/ccff_loader.sv
// ccff_loader: serialises 32-bit bitstream words MSB-first into a configuration chain.
// Define CCFF_TAIL_CHECK_EN to add an 8-cycle tail readback check after the load.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN     = 2048,
    parameter int PRESET_CYCLES = 4
) (
    input  logic              tck_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              config_enable_o,
    output logic              preset_o,
    output logic              progclk_en_o,
    output logic              ccff_head_o,
    input  logic              ccff_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int PW = $clog2(PRESET_CYCLES + 1);
    localparam int BW = $clog2(WORD_W);
`ifdef CCFF_TAIL_CHECK_EN
    localparam state_t END_ST = CHECK;
`else
    localparam state_t END_ST = DONE;
`endif
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_pcnt;
    logic [BW-1:0]     r_bits;
    logic [WORD_W-1:0] r_shreg;
    logic              r_head;
    logic              w_accept;
    assign w_accept = (r_state == LOAD) && word_valid_i;
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_bits  <= '0;
            r_shreg <= '0;
            r_head  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pcnt  <= (r_state == PRESET) ? r_pcnt + 1'b1 : '0;
            r_bits  <= (r_state == SHIFT || r_state == CHECK) ? r_bits + 1'b1 : '0;
            if (r_state == IDLE && start_i) r_cnt <= CW'(CHAIN_LEN);
            else if (r_state == SHIFT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_accept) r_shreg <= word_i;
            else if (r_state == SHIFT) r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
            if (r_state == SHIFT) r_head <= r_shreg[WORD_W-1];
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = PRESET;
            PRESET:  if (r_pcnt == PW'(PRESET_CYCLES - 1)) w_next = LOAD;
            LOAD:    if (word_valid_i) w_next = SHIFT;
            SHIFT:   if (r_bits == BW'(WORD_W - 1)) w_next = (r_cnt == CW'(1)) ? END_ST : LOAD;
`ifdef CCFF_TAIL_CHECK_EN
            CHECK:   if (r_bits == BW'(CHECK_LEN - 1)) w_next = DONE;
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // r_head keeps the last shifted bit so a LOAD stall leaves the head line steady
    assign ccff_head_o     = (r_state == SHIFT) ? r_shreg[WORD_W-1] : (r_state == CHECK) ? 1'b0 : r_head;
    assign word_ready_o    = (r_state == LOAD);
    assign preset_o        = (r_state == PRESET);
    assign progclk_en_o    = (r_state == SHIFT) || (r_state == CHECK);
    assign config_enable_o = (r_state == PRESET) || (r_state == LOAD) || progclk_en_o;
    assign busy_o          = (r_state != IDLE);
    assign done_o          = (r_state == DONE);
`ifdef CCFF_TAIL_CHECK_EN
    ccff_tail_checker u_chk (
        .clk   (tck_i),
        .rst   (rst_i),
        .i_clr (r_state == IDLE && start_i),
        .i_cap (r_state == SHIFT && r_cnt > CW'(CHAIN_LEN - CHECK_LEN)),
        .i_bit (r_shreg[WORD_W-1]),
        .i_chk (r_state == CHECK),
        .i_tail(ccff_tail_i),
        .o_err (error_o)
    );
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail_i;
    assign error_o = 1'b0;
`endif
endmodule
